// File: rtl/decp_pkg.sv
// Shared constants and helpers for the DEM decouple sequence generator.
// Imported by the LFSR sub-module and the generator top level.
package decp_pkg;

  localparam int          LFSR_W    = 16;
  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci: taps at bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic signed [1:0] S_NEG  = -2'sd1;
  localparam logic signed [1:0] S_ZERO = 2'sd0;
  localparam logic signed [1:0] S_POS  = 2'sd1;

  function automatic int sat(input int val, input int lim);
    if (val > lim) return lim;
    if (val < -lim) return -lim;
    return val;
  endfunction

endpackage

// File: rtl/decp_lfsr.sv
// 16-bit Fibonacci LFSR used as the dither source.
// Steps on en_i, reloads SEED on clr_i or reset.
module decp_lfsr
  import decp_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic bit0_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= SEED;
    end else if (clr_i) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit0_o = lfsr_q[0];

endmodule

// File: rtl/decp_gen_p.sv
// Decouple sequence generator: splits V into gama+beta for two DEM
// branches, steering the odd remainder with a noise-shaping loop.
module decp_gen_p
  import decp_pkg::*;
#(
  parameter int N         = 18,
  parameter int VW        = $clog2(N + 1),
  parameter int HW        = $clog2(N / 2 + 1),
  parameter int ORDER     = 1,
  parameter int STATE_LIM = 4,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          v_valid,
  input  logic [VW-1:0] v_in,
  input  logic          dither_en,
  output logic          out_valid,
  output logic [HW-1:0] gama,
  output logic [HW-1:0] beta,
  output logic          sat_err
);

  localparam int SW = $clog2(2 * STATE_LIM + 4) + 1;
  localparam int YW = SW + 3;

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("decp_gen_p: ORDER must be 1 or 2");
  end

  logic                 acc;
  logic                 over;
  logic [VW-1:0]        vc;
  logic                 lfsr_b0;
  logic signed [1:0]    d, s;
  logic signed [YW-1:0] y;
  logic [VW:0]          vs;
  logic [HW-1:0]        g_d, b_d;
  logic signed [SW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic                 ov_q, se_q;
  logic [HW-1:0]        gama_q, beta_q;

  assign acc = v_valid & ~clr;

  decp_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (clr),
    .en_i   (acc),
    .bit0_o (lfsr_b0)
  );

  always_comb begin
    over = v_in > VW'(N);
    vc   = over ? VW'(N) : v_in;
    d    = !dither_en ? S_ZERO : (lfsr_b0 ? S_POS : S_NEG);
    y    = YW'(x1_q) + YW'(d);
    if (ORDER == 2) begin
      y = y + YW'(x1_q) + YW'(x2_q);
    end
    // ties (y == 0) go negative
    s    = !vc[0] ? S_ZERO : (y[YW-1] ? S_POS : S_NEG);
    vs   = {1'b0, vc} + {{(VW - 1){s[1]}}, s};
    g_d  = HW'(vs >> 1);
    b_d  = HW'(vc - VW'(vs >> 1));
    x1_d = SW'(sat(int'(x1_q) + int'(s), STATE_LIM));
    x2_d = '0;
    if (ORDER == 2) begin
      x2_d = SW'(sat(int'(x2_q) + int'(x1_d), 2 * STATE_LIM));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (clr) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (acc) begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ov_q   <= 1'b0;
      gama_q <= '0;
      beta_q <= '0;
      se_q   <= 1'b0;
    end else begin
      ov_q <= acc;
      if (acc) begin
        gama_q <= g_d;
        beta_q <= b_d;
        se_q   <= over;
      end
    end
  end

  assign out_valid = ov_q;
  assign gama      = gama_q;
  assign beta      = beta_q;
  assign sat_err   = se_q;

endmodule

// File: tb/tb_decp_gen_p.sv
// Self-checking bench for decp_gen_p: ORDER=1 and ORDER=2 instances
// driven in parallel and checked against an integer reference model.
module tb_decp_gen_p;

  localparam int N   = 18;
  localparam int VW  = 5;
  localparam int HW  = 4;
  localparam int LIM = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic v_valid = 1'b0;
  logic dither_en = 1'b0;
  logic [VW-1:0] v_in = '0;

  logic ov1, se1, ov2, se2;
  logic [HW-1:0] g1, b1, g2, b2;

  always #5 clk = ~clk;

  decp_gen_p #(.N(N), .ORDER(1), .STATE_LIM(LIM), .SEED(SEED)) u1 (
    .clk(clk), .rstn(rstn), .clr(clr), .v_valid(v_valid),
    .v_in(v_in), .dither_en(dither_en), .out_valid(ov1),
    .gama(g1), .beta(b1), .sat_err(se1)
  );

  decp_gen_p #(.N(N), .ORDER(2), .STATE_LIM(LIM), .SEED(SEED)) u2 (
    .clk(clk), .rstn(rstn), .clr(clr), .v_valid(v_valid),
    .v_in(v_in), .dither_en(dither_en), .out_valid(ov2),
    .gama(g2), .beta(b2), .sat_err(se2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          mx1[2], mx2[2], mg[2], mb[2];
  bit          mv[2], ms[2];
  logic [15:0] ml[2];

  typedef struct {
    int v; int g; int b; int se; int x1;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset(input bit outs);
    for (int k = 0; k < 2; k++) begin
      mx1[k] = 0; mx2[k] = 0; ml[k] = SEED; mv[k] = 0;
      if (outs) begin
        mg[k] = 0; mb[k] = 0; ms[k] = 0;
      end
    end
  endtask

  task automatic model_step(input int k, input bit vv, input int v,
                            input bit den, input bit c);
    int vc, dd, yy, ss, g;
    bit fb;
    if (c) begin
      mx1[k] = 0; mx2[k] = 0; ml[k] = SEED; mv[k] = 0;
      return;
    end
    if (!vv) begin
      mv[k] = 0;
      return;
    end
    vc = (v > N) ? N : v;
    dd = den ? (ml[k][0] ? 1 : -1) : 0;
    yy = (k == 0) ? mx1[k] + dd : mx2[k] + 2 * mx1[k] + dd;
    ss = (vc % 2 == 0) ? 0 : ((yy >= 0) ? -1 : 1);
    g  = (vc + ss) / 2;
    mv[k] = 1; mg[k] = g; mb[k] = vc - g; ms[k] = (v > N);
    mx1[k] = clampi(mx1[k] + ss, LIM);
    if (k == 1) mx2[k] = clampi(mx2[k] + mx1[k], 2 * LIM);
    fb = ml[k][0] ^ ml[k][2] ^ ml[k][3] ^ ml[k][5];
    ml[k] = {fb, ml[k][15:1]};
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov1"}, int'(ov1), int'(mv[0]));
    chk({tag, ".g1"},  int'(g1),  mg[0]);
    chk({tag, ".b1"},  int'(b1),  mb[0]);
    chk({tag, ".se1"}, int'(se1), int'(ms[0]));
    chk({tag, ".x1_1"}, int'($signed(u1.x1_q)), mx1[0]);
    chk({tag, ".ov2"}, int'(ov2), int'(mv[1]));
    chk({tag, ".g2"},  int'(g2),  mg[1]);
    chk({tag, ".b2"},  int'(b2),  mb[1]);
    chk({tag, ".se2"}, int'(se2), int'(ms[1]));
    chk({tag, ".x1_2"}, int'($signed(u2.x1_q)), mx1[1]);
    chk({tag, ".x2_2"}, int'($signed(u2.x2_q)), mx2[1]);
  endtask

  task automatic step(input bit vv, input int v, input bit den,
                      input bit c, input string tag);
    v_valid = vv; v_in = VW'(v); dither_en = den; clr = c;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, vv, v, den, c);
    check_all(tag);
  endtask

  int vin_rec[12];
  int rg1[12], rb1[12], rg2[12], rb2[12];

  initial begin
    int sum, v, a1, a2;
    tbl[0] = '{6, 3, 3, 0, 0};
    tbl[1] = '{5, 2, 3, 0, -1};
    tbl[2] = '{5, 3, 2, 0, 0};
    tbl[3] = '{5, 2, 3, 0, -1};
    tbl[4] = '{5, 3, 2, 0, 0};
    tbl[5] = '{19, 9, 9, 1, 0};
    tbl[6] = '{31, 9, 9, 1, 0};

    model_reset(1);
    #12;
    check_all("reset");
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(1, tbl[i].v, 0, 0, "dir");
      chk($sformatf("tbl%0d.g", i),  int'(g1),  tbl[i].g);
      chk($sformatf("tbl%0d.b", i),  int'(b1),  tbl[i].b);
      chk($sformatf("tbl%0d.se", i), int'(se1), tbl[i].se);
      chk($sformatf("tbl%0d.x1", i), int'($signed(u1.x1_q)), tbl[i].x1);
    end
    step(1, 18, 0, 0, "n18");
    chk("n18.se", int'(se1), 0);

    // idle gaps, then clr colliding with a sample
    step(1, 7, 1, 0, "pre_idle");
    for (int i = 0; i < 3; i++) step(0, 11, 1, 0, "idle");
    step(1, 9, 0, 1, "clr");
    chk("clr.ov", int'(ov1), 0);
    step(1, 5, 0, 0, "post_clr");
    chk("post_clr.g", int'(g1), 2);
    chk("post_clr.b", int'(b1), 3);
    chk("post_clr.g2", int'(g2), 2);

    // ORDER=2 stability, random odd inputs, dither on
    step(0, 0, 0, 1, "clr2");
    sum = 0;
    for (int i = 0; i < 10000; i++) begin
      v = 2 * int'($urandom_range(0, 8)) + 1;
      step(1, v, 1, 0, "rand");
      chk("rand.sum_vc", int'(g2) + int'(b2), v);
      sum += int'(g2) - int'(b2);
      a1 = int'($signed(u2.x1_q)); a2 = int'($signed(u2.x2_q));
      chk("rand.x1_lim", int'(a1 <= LIM && a1 >= -LIM), 1);
      chk("rand.x2_lim", int'(a2 <= 2 * LIM && a2 >= -2 * LIM), 1);
    end
    chk("rand.runsum", int'(sum <= 64 && sum >= -64), 1);

    // reference burst after clr
    step(0, 0, 0, 1, "clr3");
    for (int i = 0; i < 12; i++) begin
      vin_rec[i] = int'($urandom_range(0, 31));
      step(1, vin_rec[i], 1, 0, "burst_a");
      rg1[i] = mg[0]; rb1[i] = mb[0]; rg2[i] = mg[1]; rb2[i] = mb[1];
    end
    for (int i = 0; i < 5; i++) step(1, int'($urandom_range(0, 31)), 1, 0, "burst_b");
    #2 rstn = 1'b0;
    #1;
    model_reset(1);
    check_all("midrst");
    #2 rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1, vin_rec[i], 1, 0, "burst_c");
      chk($sformatf("replay%0d.g1", i), int'(g1), rg1[i]);
      chk($sformatf("replay%0d.b1", i), int'(b1), rb1[i]);
      chk($sformatf("replay%0d.g2", i), int'(g2), rg2[i]);
      chk($sformatf("replay%0d.b2", i), int'(b2), rb2[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
